// File: rtl/gcd_seq.sv
// gcd_seq: iterative binary (Stein) GCD engine.
// One operation in flight. A small shift/subtract datapath is reused over
// many cycles. Operands are WIDTH bits, taken as magnitudes when SIGNED=1.
// The FSM state is exported on dbg_state so that checkers can bind to it.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer may not assume a transfer
// until it sees ready high at an edge. in_ready is high only in IDLE, so
// in_valid is ignored while busy. out_valid is high only in DONE and is
// held, with gcd_out/coprime stable, until out_ready is seen. IDLE and DONE
// never overlap, so an accept and a result handoff never share an edge.
module gcd_seq #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic             coprime,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    // k counts the shared factors of two. It never exceeds WIDTH-1.
    localparam int KW = $clog2(WIDTH) + 1;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0]    KONE = {{(KW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_TWOS   = 3'd2,
        S_ODDA   = 3'd3,
        S_REDUCE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] res_q;
    logic             cop_q;

    // Decoded datapath conditions.
    logic             a_zero, b_zero, a_odd, b_odd, a_gt_b;
    logic [WIDTH-1:0] diff_ab, diff_ba, shifted;

    // Two's-complement magnitude. The most negative value maps to 2^(WIDTH-1),
    // and that still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1])
            return (~v) + ONE;
        else
            return v;
    endfunction

    // Combinational decode of the a/b registers. The subtractions are only used
    // when the larger operand is the minuend, so they never wrap.
    always_comb begin
        a_zero  = (a_q == '0);
        b_zero  = (b_q == '0);
        a_odd   = a_q[0];
        b_odd   = b_q[0];
        a_gt_b  = (a_q > b_q);
        diff_ab = a_q - b_q;
        diff_ba = b_q - a_q;
        shifted = a_q << k_q;
    end

    // State register. An asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: exactly one step of the Stein algorithm per clock.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (a_zero || b_zero) ? S_DONE : S_TWOS;
            S_TWOS:   if (a_odd || b_odd) state_nxt = S_ODDA;
            S_ODDA:   if (a_odd) state_nxt = S_REDUCE;
            S_REDUCE: if (b_zero) state_nxt = S_DONE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath. Load the magnitudes on accept, then shift and subtract.
    // Capture the result on the way into DONE and hold it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            res_q <= '0;
            cop_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q <= magnitude(a_in);
                        b_q <= magnitude(b_in);
                        k_q <= '0;
                    end
                end
                S_CHECK: begin
                    // k is still zero here, so the surviving operand is the result.
                    if (a_zero) begin
                        res_q <= b_q;
                        cop_q <= (b_q == ONE);
                    end else if (b_zero) begin
                        res_q <= a_q;
                        cop_q <= (a_q == ONE);
                    end
                end
                S_TWOS: begin
                    if (!a_odd && !b_odd) begin
                        a_q <= a_q >> 1;
                        b_q <= b_q >> 1;
                        k_q <= k_q + KONE;
                    end
                end
                S_ODDA: begin
                    if (!a_odd)
                        a_q <= a_q >> 1;
                end
                S_REDUCE: begin
                    // a is odd on entry and stays odd: it only ever takes an odd b.
                    if (b_zero) begin
                        res_q <= shifted;
                        cop_q <= (shifted == ONE);
                    end else if (!b_odd) begin
                        b_q <= b_q >> 1;
                    end else if (a_gt_b) begin
                        a_q <= b_q;
                        b_q <= diff_ab;
                    end else begin
                        b_q <= diff_ba;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs come straight from the state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        gcd_out   = res_q;
        coprime   = cop_q;
        dbg_state = state;
    end

    // Embedded protocol checks.
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
    a_k_bound: assert property (@(posedge clk) disable iff (!rst_n)
        int'(k_q) <= WIDTH - 1);
    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(gcd_out) && $stable(coprime)));

endmodule

// File: tb/tb_gcd_seq.sv
// tb_gcd_seq: directed and scoreboarded checks of gcd_seq.
// Two instances are used: WIDTH=8 SIGNED=1, and WIDTH=16 SIGNED=0.
module tb_gcd_seq;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT: 8-bit signed ----------------
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0] a_in8 = '0, b_in8 = '0, gcd_out8;
    logic       coprime8, busy8;
    logic [2:0] dbg_state8;

    gcd_seq #(.WIDTH(8), .SIGNED(1'b1)) u_gcd8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a_in(a_in8), .b_in(b_in8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .gcd_out(gcd_out8), .coprime(coprime8), .busy(busy8),
        .dbg_state(dbg_state8)
    );

    // ---------------- DUT: 16-bit unsigned ----------------
    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
    logic [15:0] a_in16 = '0, b_in16 = '0, gcd_out16;
    logic        coprime16, busy16;
    logic [2:0]  dbg_state16;

    gcd_seq #(.WIDTH(16), .SIGNED(1'b0)) u_gcd16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a_in(a_in16), .b_in(b_in16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .gcd_out(gcd_out16), .coprime(coprime16), .busy(busy16),
        .dbg_state(dbg_state16)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [8:0]  exp8_q[$];   // {coprime, gcd}
    logic [16:0] exp16_q[$];
    int t_acc8 = 0, t_acc16 = 0, lat8 = 0, lat16 = 0;
    logic ov8_prev = 1'b0, ov16_prev = 1'b0;
    logic rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Independent reference: Euclid's remainder algorithm.
    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] t;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // ---------------- monitors ----------------
    // Sample at negedge. Inputs only change 1ns after posedge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (out_valid8 && !ov8_prev) begin
                lat8 = cyc - t_acc8;
                chk("lat8_max", 32'(lat8 <= 6 * 8 + 4), 32'd1);
            end
            ov8_prev = out_valid8;
            if (out_valid8 && out_ready8) begin
                if (exp8_q.size() == 0) begin
                    chk("unexpected8", 32'(gcd_out8), 32'hFFFF_FFFF);
                end else begin
                    e = exp8_q.pop_front();
                    chk("gcd8", 32'(gcd_out8), 32'(e[7:0]));
                    chk("coprime8", 32'(coprime8), 32'(e[8]));
                end
            end
        end else begin
            ov8_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            if (out_valid16 && !ov16_prev) begin
                lat16 = cyc - t_acc16;
                chk("lat16_max", 32'(lat16 <= 6 * 16 + 4), 32'd1);
            end
            ov16_prev = out_valid16;
            if (out_valid16 && out_ready16) begin
                if (exp16_q.size() == 0) begin
                    chk("unexpected16", 32'(gcd_out16), 32'hFFFF_FFFF);
                end else begin
                    e = exp16_q.pop_front();
                    chk("gcd16", 32'(gcd_out16), 32'(e[15:0]));
                    chk("coprime16", 32'(coprime16), 32'(e[16]));
                end
            end
        end else begin
            ov16_prev = 1'b0;
        end
    end

    // Consumer for the 16-bit side: always ready, or random when rand_rdy is set.
    always @(posedge clk) begin
        #1;
        out_ready16 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- drivers ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        int n = 0;
        @(posedge clk); #1;
        a_in8 = a; b_in8 = b; in_valid8 = 1'b1;
        do begin @(negedge clk); n++; end while (!in_ready8 && n < 500);
        if (!in_ready8) begin
            chk("accept8_timeout", 32'(in_ready8), 32'd1);
        end else begin
            t_acc8 = cyc;
            exp8_q.push_back({(e == 8'd1), e});
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a_in8 = 8'($urandom); b_in8 = 8'($urandom);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        int n = 0;
        @(posedge clk); #1;
        a_in16 = a; b_in16 = b; in_valid16 = 1'b1;
        do begin @(negedge clk); n++; end while (!in_ready16 && n < 2000);
        if (!in_ready16) begin
            chk("accept16_timeout", 32'(in_ready16), 32'd1);
        end else begin
            t_acc16 = cyc;
            exp16_q.push_back({(e == 16'd1), e});
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        a_in16 = 16'($urandom); b_in16 = 16'($urandom);
    endtask

    task automatic drain8();
        int n = 0;
        while (exp8_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        chk("drain8", 32'(exp8_q.size()), 32'd0);
    endtask

    task automatic drain16();
        int n = 0;
        while (exp16_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
        chk("drain16", 32'(exp16_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ra, rb;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_gcd8", 32'(gcd_out8), 32'd0);
        chk("rst_coprime8", 32'(coprime8), 32'd0);
        chk("rst_in_ready16", 32'(in_ready16), 32'd1);
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic signed vectors
        send8(8'd60, 8'd100, 8'd20);
        send8(8'd42, 8'd96, 8'd6);
        send8(-8'sd92, 8'd69, 8'd23);
        send8(8'd17, 8'd37, 8'd1);
        drain8();

        // Zero operands and equal operands
        send8(8'd0, 8'd0, 8'd0);
        drain8();
        send8(8'd0, -8'sd7, 8'd7);
        drain8();
        chk("lat_zero_operand", 32'(lat8), 32'd2);
        send8(8'd45, 8'd45, 8'd45);
        send8(8'h80, 8'h80, 8'd128);
        drain8();

        // Powers of two: exercises the shared-factor (k) path
        send8(8'd64, 8'h80, 8'd64);
        send8(-8'sd32, 8'h80, 8'd32);
        send8(8'd6, 8'd108, 8'd6);
        drain8();

        // Backpressure: result held, in_valid ignored while waiting
        out_ready8 = 1'b0;
        send8(8'd68, 8'd24, 8'd4);
        n = 0;
        while (!out_valid8 && n < 200) begin @(negedge clk); n++; end
        chk("bp_result_seen", 32'(out_valid8), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                a_in8 = 8'd3; b_in8 = 8'd9; in_valid8 = 1'b1;
            end else begin
                in_valid8 = 1'b0;
            end
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid8), 32'd1);
            chk("bp_gcd", 32'(gcd_out8), 32'd4);
            chk("bp_in_ready", 32'(in_ready8), 32'd0);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        drain8();
        repeat (4) @(negedge clk);
        chk("bp_no_extra_op", 32'(busy8), 32'd0);

        // Reset in the middle of REDUCE
        @(posedge clk); #1;
        a_in8 = 8'd57; b_in8 = 8'd107; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (dbg_state8 != 3'd4 && n < 50);
        chk("reached_reduce", 32'(dbg_state8), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready8), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid8), 32'd0);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_gcd", 32'(gcd_out8), 32'd0);
        chk("mid_rst_coprime", 32'(coprime8), 32'd0);
        chk("mid_rst_state", 32'(dbg_state8), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send8(8'd119, 8'd1, 8'd1);
        drain8();

        // 16-bit unsigned: directed vectors
        send16(16'd65535, 16'd255, 16'd255);
        send16(16'd40000, 16'd60000, 16'd20000);
        send16(16'd1024, 16'd768, 16'd256);
        send16(16'd0, 16'd65535, 16'd65535);
        send16(16'd12345, 16'd54321, 16'd3);
        send16(16'd32768, 16'd32768, 16'd32768);
        drain16();

        // 16-bit: back-to-back random pairs vs. the Euclid reference, random out_ready
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = (i % 13 == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
            rb = (i % 7 == 3) ? 16'($urandom_range(0, 15) << 8) : 16'($urandom_range(0, 65535));
            send16(ra, rb, ref_gcd(ra, rb));
        end
        drain16();
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the sequence must end long before this.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d n_err=%0d", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
